// File: rtl/pwm_multichannel.sv
// pwm_multichannel: prescaled shared-counter N-channel PWM with double-buffered period, prescale and duty
module pwm_multichannel #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n_a,
  input  logic                   en,
  input  logic                   load,
  input  logic [CNT_W-1:0]       period_in,
  input  logic [PRE_W-1:0]       prescale_in,
  input  logic [N_CH*CNT_W-1:0]  duty_in,
  output logic [N_CH-1:0]        pwm_out,
  output logic                   period_tick,
  output logic [CNT_W-1:0]       count
);
  logic [PRE_W-1:0] pre_cnt, pre_act, pre_sh;
  logic [CNT_W-1:0] cnt, per_act, per_sh;
  logic [N_CH*CNT_W-1:0] duty_act, duty_sh;
  logic [N_CH-1:0] cmp;
  logic pending, tick, wrap, apply;
  assign tick = en && pre_cnt == pre_act;
  assign wrap = tick && cnt >= per_act;
  assign apply = pending && (wrap || !en);
  assign count = cnt;
  for (genvar i = 0; i < N_CH; i++) begin : g_cmp
    assign cmp[i] = cnt < duty_act[i*CNT_W +: CNT_W];
  end
  always_ff @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      pre_act     <= '0;
      per_act     <= '0;
      duty_act    <= '0;
      pre_sh      <= '0;
      per_sh      <= '0;
      duty_sh     <= '0;
      pending     <= 1'b0;
    end else begin
      if (!en) begin
        pre_cnt     <= '0;
        cnt         <= '0;
        pwm_out     <= '0;
        period_tick <= 1'b0;
      end else begin
        pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
        cnt         <= tick ? (wrap ? '0 : cnt + 1'b1) : cnt;
        pwm_out     <= cmp;
        period_tick <= wrap;
      end
      if (load) begin
        pre_sh  <= prescale_in;
        per_sh  <= period_in;
        duty_sh <= duty_in;
      end
      if (load && wrap) begin
        pre_act  <= prescale_in;
        per_act  <= period_in;
        duty_act <= duty_in;
      end else if (apply) begin
        pre_act  <= pre_sh;
        per_act  <= per_sh;
        duty_act <= duty_sh;
      end
      pending <= load ? !wrap : pending && !apply;
    end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: closed-form reference checks of pwm_multichannel configs, updates and resets
module tb_pwm_multichannel;
  logic clk, rst_n_a, en, load, period_tick;
  logic [7:0] period_in, prescale_in, count;
  logic [31:0] duty_in;
  logic [3:0] pwm_out;
  int checks, errors;
  localparam logic [31:0] D_BASE = {8'd12, 8'd5, 8'd3, 8'd0};
  pwm_multichannel #(.N_CH(4), .CNT_W(8), .PRE_W(8)) dut (
    .clk(clk), .rst_n_a(rst_n_a), .en(en), .load(load),
    .period_in(period_in), .prescale_in(prescale_in), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_tick(period_tick), .count(count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic load_stopped(input int p, input int s, input logic [31:0] d);
    en = 1'b0;
    load = 1'b1;
    period_in = 8'(p);
    prescale_in = 8'(s);
    duty_in = d;
    step();
    load = 1'b0;
    step();
  endtask
  task automatic test_reset;
    rst_n_a = 1'b0;
    en = 1'b1;
    load = 1'b0;
    period_in = 8'd0;
    prescale_in = 8'd0;
    duty_in = '0;
    step();
    step();
    checks++;
    if (pwm_out !== 4'd0 || count !== 8'd0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset: pwm=%h count=%0d tick=%b, required all 0", pwm_out, count, period_tick);
    end
    #2 rst_n_a = 1'b1;
    en = 1'b0;
    step();
  endtask
  task automatic test_config(input int p, input int s, input logic [31:0] d);
    int dd[4];
    int hi[4];
    int n, w, t, c;
    logic [7:0] ec;
    logic et;
    logic [3:0] ep;
    for (int i = 0; i < 4; i++) begin
      dd[i] = int'(d[i*8 +: 8]);
      hi[i] = 0;
    end
    load_stopped(p, s, d);
    en = 1'b1;
    w = (p + 1) * (s + 1);
    n = 2 * w + 3;
    for (int j = 1; j <= n; j++) begin
      step();
      t = j / (s + 1);
      ec = 8'(t % (p + 1));
      et = (j % (s + 1) == 0) && (t % (p + 1) == 0);
      c = ((j - 1) / (s + 1)) % (p + 1);
      for (int i = 0; i < 4; i++) ep[i] = c < dd[i];
      checks += 3;
      if (count !== ec) begin
        errors++;
        $display("FAIL cfg_count p=%0d s=%0d j=%0d: got %0d, required %0d", p, s, j, count, ec);
      end
      if (period_tick !== et) begin
        errors++;
        $display("FAIL cfg_tick p=%0d s=%0d j=%0d: got %b, required %b", p, s, j, period_tick, et);
      end
      if (pwm_out !== ep) begin
        errors++;
        $display("FAIL cfg_pwm p=%0d s=%0d j=%0d: got %b, required %b", p, s, j, pwm_out, ep);
      end
      if (j <= w)
        for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] != ((dd[i] < p + 1) ? dd[i] : p + 1) * (s + 1)) begin
        errors++;
        $display("FAIL cfg_hightime p=%0d s=%0d ch%0d: got %0d clk, required %0d", p, s, i, hi[i],
                 ((dd[i] < p + 1) ? dd[i] : p + 1) * (s + 1));
      end
    end
    en = 1'b0;
    step();
  endtask
  task automatic test_duty_update;
    int c, k;
    logic [3:0] ep;
    load_stopped(9, 0, D_BASE);
    en = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      load = (j == 15);
      duty_in = (j == 15) ? {8'd12, 8'd5, 8'd7, 8'd0} : D_BASE;
      step();
      c = (j - 1) % 10;
      k = ((j - 1) / 10 >= 2) ? 7 : 3;
      ep = {c < 12, c < 5, c < k, 1'b0};
      checks += 2;
      if (count !== 8'(j % 10)) begin
        errors++;
        $display("FAIL upd_count j=%0d: got %0d, required %0d", j, count, j % 10);
      end
      if (pwm_out !== ep) begin
        errors++;
        $display("FAIL upd_pwm j=%0d: got %b, required %b", j, pwm_out, ep);
      end
    end
    load = 1'b0;
    en = 1'b0;
    step();
  endtask
  task automatic test_load_at_wrap;
    int ec;
    logic et;
    load_stopped(9, 0, D_BASE);
    en = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      load = (j == 20) || (j == 22);
      period_in = (j == 22) ? 8'd6 : 8'd4;
      step();
      ec = (j < 20) ? j % 10 : (j < 25) ? j - 20 : (j < 32) ? j - 25 : (j - 32) % 7;
      et = (j == 10) || (j == 20) || (j == 25) || (j == 32) || (j == 39);
      checks += 2;
      if (count !== 8'(ec)) begin
        errors++;
        $display("FAIL wrapload_count j=%0d: got %0d, required %0d", j, count, ec);
      end
      if (period_tick !== et) begin
        errors++;
        $display("FAIL wrapload_tick j=%0d: got %b, required %b", j, period_tick, et);
      end
    end
    load = 1'b0;
    en = 1'b0;
    step();
  endtask
  task automatic test_period_lower;
    int ec;
    logic et;
    load_stopped(9, 0, D_BASE);
    en = 1'b1;
    for (int j = 1; j <= 35; j++) begin
      load = (j == 18);
      period_in = 8'd2;
      step();
      ec = (j < 20) ? j % 10 : (j - 20) % 3;
      et = (j == 10) || (j >= 20 && (j - 20) % 3 == 0);
      checks += 2;
      if (count !== 8'(ec)) begin
        errors++;
        $display("FAIL lower_count j=%0d: got %0d, required %0d", j, count, ec);
      end
      if (period_tick !== et) begin
        errors++;
        $display("FAIL lower_tick j=%0d: got %b, required %b", j, period_tick, et);
      end
    end
    load = 1'b0;
    load_stopped(9, 0, D_BASE);
    en = 1'b1;
    for (int j = 1; j <= 7; j++) step();
    checks++;
    if (count !== 8'd7) begin
      errors++;
      $display("FAIL lower_pre got %0d, required 7", count);
    end
    en = 1'b0;
    load = 1'b1;
    period_in = 8'd2;
    step();
    load = 1'b0;
    checks++;
    if (count !== 8'd0 || pwm_out !== 4'd0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL stop_clear: count=%0d pwm=%b tick=%b, required 0", count, pwm_out, period_tick);
    end
    step();
    en = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      checks += 2;
      if (count !== 8'(j % 3)) begin
        errors++;
        $display("FAIL restart_count j=%0d: got %0d, required %0d", j, count, j % 3);
      end
      if (period_tick !== (j % 3 == 0)) begin
        errors++;
        $display("FAIL restart_tick j=%0d: got %b, required %b", j, period_tick, j % 3 == 0);
      end
    end
    en = 1'b0;
    step();
  endtask
  task automatic test_reset_mid;
    load_stopped(9, 0, D_BASE);
    en = 1'b1;
    for (int j = 1; j <= 13; j++) step();
    load = 1'b1;
    period_in = 8'd5;
    duty_in = {4{8'd8}};
    step();
    load = 1'b0;
    checks++;
    if (count !== 8'd4 || pwm_out !== 4'b1100) begin
      errors++;
      $display("FAIL premid: count=%0d pwm=%b, required 4 1100", count, pwm_out);
    end
    #2 rst_n_a = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0 || pwm_out !== 4'd0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d pwm=%b tick=%b, required 0", count, pwm_out, period_tick);
    end
    #2 rst_n_a = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++;
      if (count !== 8'd0 || pwm_out !== 4'd0 || period_tick !== 1'b1) begin
        errors++;
        $display("FAIL post_reset j=%0d: count=%0d pwm=%b tick=%b, required 0 0000 1", j, count, pwm_out,
                 period_tick);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (count !== 8'd0 || pwm_out !== 4'd0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL en_toggle: count=%0d pwm=%b tick=%b, required 0", count, pwm_out, period_tick);
    end
    en = 1'b1;
    step();
    checks++;
    if (count !== 8'd0 || period_tick !== 1'b1) begin
      errors++;
      $display("FAIL en_resume: count=%0d tick=%b, required 0 1", count, period_tick);
    end
    en = 1'b0;
    step();
  endtask
  initial begin
    int p;
    logic [31:0] d;
    checks = 0;
    errors = 0;
    test_reset();
    test_config(9, 0, D_BASE);
    test_config(3, 2, {8'd0, 8'd0, 8'd2, 8'd0});
    test_config(255, 0, {8'd255, 8'd128, 8'd1, 8'd0});
    test_config(0, 0, {8'd0, 8'd1, 8'd0, 8'd1});
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(0, 12);
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'($urandom_range(0, p + 2));
      test_config(p, $urandom_range(0, 3), d);
    end
    test_duty_update();
    test_load_at_wrap();
    test_period_lower();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
- Parametrised multi-channel PWM generator and the successor to the free-running single counter.
- One prescaler and one shared period counter drive N_CH compare channels.
- Period, prescale and per-channel duty are double-buffered, so updates take effect only at a period boundary and never produce glitched pulses.
- Sits between the register/control logic and the PWM output pins.

Parameters:
- N_CH, 4, number of PWM channels
- CNT_W, 16, width of period counter, period and duty values
- PRE_W, 8, width of prescaler value

Ports:
- clk  input  1  system clock
- rst_n_a  input  1  asynchronous active-low reset
- en  input  1  run enable; low = stopped and cleared
- load  input  1  one-cycle strobe; captures period_in, prescale_in, duty_in
- period_in  input  CNT_W  counter terminal value; period = period_in+1 ticks
- prescale_in  input  PRE_W  tick divider; tick every prescale_in+1 enabled cycles
- duty_in  input  N_CH*CNT_W  packed duties, channel i at [i*CNT_W +: CNT_W]
- pwm_out  output  N_CH  registered PWM outputs
- period_tick  output  1  one-cycle pulse on counter wrap
- count  output  CNT_W  current period counter value

Behaviour:
- Reset (async, rst_n_a=0) clears everything to 0:
  - pre_cnt, cnt, count, pwm_out, period_tick.
  - Active and shadow period/prescale/duty registers.
  - Pending flag.
- Prescaler:
  - While en=1, pre_cnt counts 0..prescale_act.
  - tick=1 in the cycle pre_cnt==prescale_act; pre_cnt then returns to 0.
  - prescale_act=0 gives tick every cycle.
- Counter (on tick only):
  - If cnt>=period_act: cnt<=0 and wrap=1.
  - Else cnt<=cnt+1.
  - The ">=" comparison guarantees recovery if period_act is lowered below cnt.
  - count = cnt.
- period_tick: registered; asserted for exactly one cycle, in the cycle after wrap.
- Shadow/load:
  - load=1 copies the inputs into shadow registers and sets pending.
  - Repeated loads overwrite the shadow (last write wins).
- Active update: shadow→active and pending cleared when pending=1 and either wrap=1 or en=0.
  - While en=0, a load therefore takes effect on the next cycle.
- load coincident with wrap: the new input values go directly to active (bypass) and pending clears.
  - Any older shadow contents are discarded.
- Output compare, registered, one cycle latency after cnt:
  - pwm_out[i] <= (cnt < duty_act[i]).
  - duty=0 → constantly low.
  - duty>period_act → constantly high (100%).
  - Expected high time = duty ticks per period_act+1 ticks.
- en=0:
  - pre_cnt and cnt synchronously cleared to 0.
  - pwm_out <= 0; period_tick <= 0.
  - Active and shadow registers retained.
- Re-enable: counting restarts from cnt=0, pre_cnt=0; the first pwm_out value appears one cycle after en rises.
- Reset mid-operation: immediate clear; no pending load survives.
- All arithmetic is unsigned, with no overflow beyond CNT_W.
  - period_in all-ones gives 2^CNT_W ticks per period; cnt wraps via the >= rule.

Test Plan:
- N_CH=4, CNT_W=8; load period=9, prescale=0, duty={0,3,5,12}, en=1 → over 10 cycles ch0 high 0, ch1 3, ch2 5, ch3 10 (always high); period_tick every 10 cycles; count sequence 0..9.
- prescale=2, period=3, duty ch1=2 → tick every 3 cycles; period = 12 clk; ch1 high 6 clk per period; period_tick spacing 12.
- Running at period=9: load duty ch1=7 at cnt=4 → ch1 keeps 3-tick pulse until the next wrap, then 7-tick pulses; no truncated or extended pulse in between.
- load asserted exactly in the wrap cycle with period=4 → next period already 5 ticks; pending=0; a second load two cycles later applies only at the following wrap.
- Lower period from 9 to 2 while cnt=7 (pending applies at wrap): verify wrap at 9 then periods of 3; separately, force active period 2 with cnt=7 via en=0 load/re-enable → cnt restarts at 0, no hang.
- Assert rst_n_a low mid-period with a pending load → all outputs 0 asynchronously; after release with en=1, counter runs with period 0 (period_tick every tick) and pwm_out stays 0; a toggle of en clears cnt and pwm_out on the next edge.
